// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous display updates,
// leading-zero suppression, per-digit blink and ghost-blanking between slots.
module seven_seg_scan_driver #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter int unsigned HEX_MODE       = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned SlotW  = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SlotW-1:0]      SlotLast  = SlotW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0]       IdxLast   = IdxW'(NUM_DIGITS - 1);
  localparam logic [BlinkW-1:0]     BlinkLast = BlinkW'(BLINK_FRAMES - 1);
  localparam logic [7:0]            SegOff    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AnOff     = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [SlotW-1:0]        slot_q;
  logic [IdxW-1:0]         idx_q;
  logic [BlinkW-1:0]       blink_cnt_q;
  logic                    blink_off_q;
  logic                    pend_valid_q;
  logic [4*NUM_DIGITS-1:0] pend_val_q, disp_val_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, disp_dp_q;
  logic [NUM_DIGITS-1:0]   pend_blink_q, disp_blink_q;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    slot_last, wrap;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blink, cur_lz, all_zero;
  logic [NUM_DIGITS-1:0]   lz, an_raw;
  logic [7:0]              seg_raw;

  // Segment pattern in {g,f,e,d,c,b,a} order, active-high.
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0111111;
      4'h1:    s = 7'b0000110;
      4'h2:    s = 7'b1011011;
      4'h3:    s = 7'b1001111;
      4'h4:    s = 7'b1100110;
      4'h5:    s = 7'b1101101;
      4'h6:    s = 7'b1111101;
      4'h7:    s = 7'b0000111;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1101111;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b1111100;
      4'hC:    s = 7'b0111001;
      4'hD:    s = 7'b1011110;
      4'hE:    s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    if (HEX_MODE == 0 && n > 4'h9) s = 7'b0000000;
    return s;
  endfunction

  always_comb begin
    slot_last = (slot_q == SlotLast);
    wrap      = slot_last && (idx_q == IdxLast);

    // A digit is a leading zero when it and every digit above it are zero.
    all_zero = 1'b1;
    lz       = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (disp_val_q[4*i +: 4] == 4'h0);
      lz[i]    = all_zero;
    end

    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    an_raw    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib   = disp_val_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blink = disp_blink_q[i];
        cur_lz    = lz[i];
        an_raw[i] = 1'b1;
      end
    end

    seg_raw = {cur_dp, decode(cur_nib)};
    if (blank_lz && cur_lz)        seg_raw[6:0] = 7'b0000000;
    if (blink_off_q && cur_blink)  seg_raw      = 8'h00;
    // Ghost-blank: no anode is driven while the segment lines settle.
    if (slot_q == '0)              an_raw       = '0;

    seg_d      = seg_raw ^ SegOff;
    an_d       = an_raw ^ AnOff;
    frame_done = wrap & rst_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q       <= '0;
      idx_q        <= '0;
      blink_cnt_q  <= '0;
      blink_off_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blink_q <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blink_q <= '0;
      seg_q        <= SegOff;
      an_q         <= AnOff;
    end else begin
      seg_q  <= seg_d;
      an_q   <= an_d;
      slot_q <= slot_last ? '0 : slot_q + 1'b1;
      if (slot_last) idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;

      if (wrap) begin
        if (blink_cnt_q == BlinkLast) begin
          blink_cnt_q <= '0;
          blink_off_q <= ~blink_off_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
        // Commit only at the frame boundary; a coincident load bypasses pending.
        if (load) begin
          disp_val_q   <= value_in;
          disp_dp_q    <= dp_in;
          disp_blink_q <= blink_mask;
        end else if (pend_valid_q) begin
          disp_val_q   <= pend_val_q;
          disp_dp_q    <= pend_dp_q;
          disp_blink_q <= pend_blink_q;
        end
        pend_valid_q <= 1'b0;
      end else if (load) begin
        pend_val_q   <= value_in;
        pend_dp_q    <= dp_in;
        pend_blink_q <= blink_mask;
        pend_valid_q <= 1'b1;
      end
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
